// File: rtl/grf_wport_arb_pkg.sv
// grf_wport_arb_pkg: shared widths, zero-register constant and aux-entry type
// for the grf write-port arbiter.
package grf_wport_arb_pkg;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam logic [AW-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } aux_entry_t;
endpackage

// File: rtl/grf_aux_fifo.sv
// grf_aux_fifo: circular buffer of aux writes with per-entry valid,
// address squash and pending-write lookup.
module grf_aux_fifo
   import grf_wport_arb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          push_i,
   input  logic [AW-1:0] push_addr_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   input  logic          squash_i,
   input  logic [AW-1:0] squash_addr_i,
   input  logic [AW-1:0] raddr1_i,
   input  logic [AW-1:0] raddr2_i,
   output logic [CW-1:0] count_o,
   output aux_entry_t    head_o,
   output logic          any_valid_o,
   output logic          match1_o,
   output logic          match2_o
);
   aux_entry_t    mem_q [DEPTH];
   aux_entry_t    mem_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The slot being pushed is always free, so a same-cycle squash never hits the new entry.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++)
         if (squash_i && mem_q[i].addr == squash_addr_i) mem_d[i].valid = 1'b0;
      if (pop_i) mem_d[rd_q].valid = 1'b0;
      if (push_i) mem_d[wr_q] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
      rd_d  = !pop_i ? rd_q : (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      wr_d  = !push_i ? wr_q : (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      any_valid_o = 1'b0;
      match1_o    = 1'b0;
      match2_o    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_valid_o |= mem_q[i].valid;
         match1_o    |= mem_q[i].valid && mem_q[i].addr == raddr1_i && raddr1_i != REG_ZERO;
         match2_o    |= mem_q[i].valid && mem_q[i].addr == raddr2_i && raddr2_i != REG_ZERO;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/grf_wport_arb.sv
// grf_wport_arb: shares the grf write port between the W stage (fixed priority)
// and a FIFO-buffered aux writer, with pending lookups and a starvation stall request.
module grf_wport_arb
   import grf_wport_arb_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          PW_En,
   input  logic [AW-1:0] PW_Addr,
   input  logic [DW-1:0] PW_Data,
   input  logic          AX_Valid,
   input  logic [AW-1:0] AX_Addr,
   input  logic [DW-1:0] AX_Data,
   output logic          AX_Ready,
   input  logic [AW-1:0] RAddr1,
   input  logic [AW-1:0] RAddr2,
   output logic          Pend1,
   output logic          Pend2,
   output logic          StallReq,
   output logic          RegWrite,
   output logic [AW-1:0] WAddr,
   output logic [DW-1:0] WData
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] count;
   aux_entry_t    head;
   logic          any_valid, match1, match2;
   logic          pipe_wr, push, pop;
   logic [SW-1:0] stv_q, stv_d;

   assign pipe_wr  = PW_En && PW_Addr != REG_ZERO;
   assign AX_Ready = Reset && count < CW'(DEPTH);
   assign push     = AX_Valid && AX_Ready && AX_Addr != REG_ZERO;
   // A squashed head retires silently even while the pipe owns the port.
   assign pop      = Reset && count != '0 && (!head.valid || !pipe_wr);

   grf_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clk          (Clk),
      .Reset        (Reset),
      .push_i       (push),
      .push_addr_i  (AX_Addr),
      .push_data_i  (AX_Data),
      .pop_i        (pop),
      .squash_i     (pipe_wr),
      .squash_addr_i(PW_Addr),
      .raddr1_i     (RAddr1),
      .raddr2_i     (RAddr2),
      .count_o      (count),
      .head_o       (head),
      .any_valid_o  (any_valid),
      .match1_o     (match1),
      .match2_o     (match2)
   );

   always_comb begin
      stv_d = (pop || !any_valid) ? '0 :
              (pipe_wr && stv_q < SW'(STARVE_LIMIT)) ? stv_q + 1'b1 : stv_q;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) stv_q <= '0;
      else        stv_q <= stv_d;
   end

   assign RegWrite = Reset && (pipe_wr || head.valid);
   assign WAddr    = !Reset ? REG_ZERO : pipe_wr ? PW_Addr : head.valid ? head.addr : REG_ZERO;
   assign WData    = !Reset ? '0 : pipe_wr ? PW_Data : head.valid ? head.data : '0;
   assign Pend1    = Reset && match1;
   assign Pend2    = Reset && match2;
   assign StallReq = Reset && stv_q >= SW'(STARVE_LIMIT);
endmodule

// File: tb/tb_grf_wport_arb.sv
// tb_grf_wport_arb: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the write-port arbiter.
module tb_grf_wport_arb;
   import grf_wport_arb_pkg::*;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic          Clk = 1'b0, Reset = 1'b0, PW_En = 1'b0, AX_Valid = 1'b0;
   logic [AW-1:0] PW_Addr = '0, AX_Addr = '0, RAddr1 = '0, RAddr2 = '0, WAddr;
   logic [DW-1:0] PW_Data = '0, AX_Data = '0, WData;
   logic          AX_Ready, Pend1, Pend2, StallReq, RegWrite;
   int            errors = 0, checks = 0;

   typedef struct {
      bit            v;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;
   ent_t q[$];
   int   starve = 0;

   always #5 Clk = ~Clk;

   grf_wport_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .Clk(Clk), .Reset(Reset), .PW_En(PW_En), .PW_Addr(PW_Addr), .PW_Data(PW_Data),
      .AX_Valid(AX_Valid), .AX_Addr(AX_Addr), .AX_Data(AX_Data), .AX_Ready(AX_Ready),
      .RAddr1(RAddr1), .RAddr2(RAddr2), .Pend1(Pend1), .Pend2(Pend2), .StallReq(StallReq),
      .RegWrite(RegWrite), .WAddr(WAddr), .WData(WData)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit pending(input logic [AW-1:0] a);
      bit hit = 0;
      foreach (q[i]) hit |= q[i].v && q[i].a == a && a != REG_ZERO;
      return hit;
   endfunction

   // Compare every output against the model, then clock once and advance the model.
   task automatic step();
      bit            pipe, ready, hv, anyv, push, popped;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      #1;
      pipe  = PW_En && PW_Addr != REG_ZERO;
      ready = Reset && q.size() < DEPTH;
      hv    = q.size() > 0 && q[0].v;
      anyv  = 0;
      foreach (q[i]) anyv |= q[i].v;
      ea = !Reset ? '0 : pipe ? PW_Addr : hv ? q[0].a : '0;
      ed = !Reset ? '0 : pipe ? PW_Data : hv ? q[0].d : '0;
      check("AX_Ready", AX_Ready, ready);
      check("RegWrite", RegWrite, Reset && (pipe || hv));
      check("WAddr", WAddr, ea);
      check("WData", WData, ed);
      check("Pend1", Pend1, Reset && pending(RAddr1));
      check("Pend2", Pend2, Reset && pending(RAddr2));
      check("StallReq", StallReq, Reset && starve >= LIMIT);
      push   = ready && AX_Valid && AX_Addr != REG_ZERO;
      popped = q.size() > 0 && (!q[0].v || !pipe);
      @(posedge Clk);
      if (!Reset) begin
         q.delete();
         starve = 0;
      end else begin
         starve = (popped || !anyv) ? 0 : (pipe && starve < LIMIT) ? starve + 1 : starve;
         if (pipe) foreach (q[i]) if (q[i].a == PW_Addr) q[i].v = 0;
         if (popped) void'(q.pop_front());
         if (push) q.push_back('{v: 1'b1, a: AX_Addr, d: AX_Data});
      end
      #1;
   endtask

   task automatic aux(input bit v, input int a, input logic [DW-1:0] d);
      AX_Valid = v;
      AX_Addr  = AW'(a);
      AX_Data  = d;
   endtask

   task automatic pipe(input bit en, input int a, input logic [DW-1:0] d);
      PW_En   = en;
      PW_Addr = AW'(a);
      PW_Data = d;
   endtask

   initial begin
      // reset held with an aux offer pending
      aux(1, 5, 32'h1234);
      repeat (2) begin
         #1;
         check("rst_ready", AX_Ready, 0);
         check("rst_we", RegWrite, 0);
         step();
      end
      Reset = 1'b1;
      aux(0, 0, 0);
      step();
      // single aux write, 1-cycle latency
      aux(1, 5, 32'hDEADBEEF);
      step();
      aux(0, 0, 0);
      #1;
      check("lat_we", RegWrite, 1);
      check("lat_addr", WAddr, 5);
      check("lat_data", WData, 32'hDEADBEEF);
      step();
      // starvation under continuous pipe writes
      pipe(1, 3, 32'h33);
      aux(1, 7, 32'h11);
      step();
      aux(0, 0, 0);
      for (int i = 0; i < LIMIT; i++) begin
         #1;
         check("stv_low", StallReq, 0);
         step();
      end
      #1;
      check("stv_high", StallReq, 1);
      check("stv_pipe_addr", WAddr, 3);
      step();
      pipe(0, 0, 0);
      #1;
      check("stv_drain_addr", WAddr, 7);
      check("stv_drain_data", WData, 32'h11);
      step();
      #1;
      check("stv_clear", StallReq, 0);
      // pipe write squashes a queued aux entry to the same register
      RAddr1 = 9;
      aux(1, 9, 32'hA);
      step();
      aux(0, 0, 0);
      pipe(1, 9, 32'hB);
      #1;
      check("sq_pend_before", Pend1, 1);
      check("sq_pipe_data", WData, 32'hB);
      step();
      pipe(0, 0, 0);
      #1;
      check("sq_pend_after", Pend1, 0);
      check("sq_no_write", RegWrite, 0);
      step();
      RAddr1 = 0;
      // fill, then pop and push around a full FIFO
      pipe(1, 3, 32'h3);
      aux(1, 10, 32'h1);
      step();
      aux(1, 11, 32'h2);
      step();
      #1;
      check("full_ready", AX_Ready, 0);
      pipe(0, 0, 0);
      aux(1, 12, 32'h3);
      step();
      #1;
      check("ready_rises", AX_Ready, 1);
      check("pop2_addr", WAddr, 11);
      step();
      aux(0, 0, 0);
      #1;
      check("pushpop_head", WAddr, 12);
      check("pushpop_ready", AX_Ready, 1);
      step();
      // zero-address aux is discarded; reset drops queued entries
      aux(1, 0, 32'h5);
      step();
      aux(0, 0, 0);
      #1;
      check("zero_discard", RegWrite, 0);
      pipe(1, 3, 32'h3);
      aux(1, 13, 32'hC);
      step();
      aux(1, 14, 32'hD);
      step();
      aux(0, 0, 0);
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      pipe(0, 0, 0);
      #1;
      check("rst_drop_we", RegWrite, 0);
      check("rst_drop_ready", AX_Ready, 1);
      step();
      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         Reset = ($urandom_range(0, 59) != 0);
         pipe($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom);
         aux($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
         RAddr1 = AW'($urandom_range(0, 7));
         RAddr2 = AW'($urandom_range(0, 7));
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
